fft_iter_addr_gen: RTL and testbench
====================================

Name: fft_iter_addr_gen

Overview:
- Address generator for the single-butterfly iterative radix-2 FFT.
- It is the consumer of the control unit's ADDR_EN strobe and sequences butterfly and layer indices for in-place DIT processing of N = 2^LAYERS points.
- It drives the data RAM read-pair addresses, the registered write-pair addresses, the twiddle ROM address and layer status back to the datapath.
- One ADDR_EN pulse retires the current butterfly and advances to the next.

Parameters:
- LAYERS, 5: number of FFT stages; N = 2^LAYERS.
- BUTTERFLYES, 16: butterflies per layer; must equal 2^(LAYERS-1).
- LayWL, 3: layer counter width; 2^LayWL >= LAYERS.
- ButtWL, 4: butterfly counter width; equals LAYERS-1.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  global enable; when 0 all state holds (RST still acts).
- START  in  1  begins/restarts a transform.
- ADDR_EN  in  1  one-cycle strobe: butterfly at RD addresses is being written, advance.
- RD_ADDR_A  out  ButtWL+1  upper-leg read address.
- RD_ADDR_B  out  ButtWL+1  lower-leg read address.
- TW_ADDR  out  ButtWL  twiddle ROM index.
- WR_ADDR_A  out  ButtWL+1  write address, upper leg, registered.
- WR_ADDR_B  out  ButtWL+1  write address, lower leg, registered.
- LAYER  out  LayWL  current layer index.
- FIRST  out  1  high while LAYER==0 and state RUN.
- BUSY  out  1  high in RUN.
- DONE  out  1  one-cycle pulse after last butterfly of last layer.
- SEQ_ERR  out  1  sticky: ADDR_EN received outside RUN.

Behaviour:
- Precedence and enable:
  - State: IDLE, RUN, FIN.
  - Priority per edge: RST > EN==0 (hold) > START > normal.
- Reset:
  - state=IDLE; counters b=0, l=0.
  - WR_ADDR_A/B=0; DONE=0; SEQ_ERR=0.
  - Outputs derived from counters are therefore RD_ADDR_A=0, RD_ADDR_B=1, TW_ADDR=0, LAYER=0, FIRST=0, BUSY=0.
- Address arithmetic (combinational from counter flops b, l; no glitch paths from inputs):
  - m = b mod 2^l.
  - RD_ADDR_A = ((b >> l) << (l+1)) | m.
  - RD_ADDR_B = RD_ADDR_A + 2^l; no overflow possible.
  - TW_ADDR = m << (LAYERS-1-l), truncated to ButtWL.
- IDLE:
  - Counters held at 0.
  - START -> RUN with b=0, l=0, SEQ_ERR cleared.
  - ADDR_EN without START: ignored for counters, sets SEQ_ERR.
- RUN, on ADDR_EN:
  - WR_ADDR_A/B <= current RD_ADDR_A/B, so the write addresses are valid from the next cycle and held until the next ADDR_EN.
  - If b < BUTTERFLYES-1: b <= b+1.
  - Else b <= 0 and:
    - if l < LAYERS-1: l <= l+1;
    - else state <= FIN.
- RUN, no ADDR_EN: all hold.
- START in RUN: immediate restart, b=0, l=0, WR_ADDR unchanged, no DONE.
- FIN:
  - DONE=1 for exactly one cycle; BUSY=0; b, l = 0.
  - Next state IDLE, unless START in that cycle -> RUN.
  - ADDR_EN in FIN sets SEQ_ERR.
- Input timing: ADDR_EN held >1 cycle counts once per cycle high; the control unit drives single-cycle strobes from its falling-edge FSM, sampled here on the rising edge.
- Total: LAYERS*BUTTERFLYES ADDR_EN pulses per transform; DONE one cycle after the final one.
- RST mid-transform: returns to IDLE in one edge, no DONE.

Test Plan:
- Reset, then check RD_ADDR_A=0, RD_ADDR_B=1, TW_ADDR=0, LAYER=0, BUSY=0, DONE=0, SEQ_ERR=0.
- START, then 1 ADDR_EN -> WR_ADDR_A/B=0/1, RD=2/3, FIRST=1; after 16 pulses LAYER=1, FIRST=0. At l=1, b=1: RD=1/3, TW=8.
- Advance to l=2, b=6 -> RD=10/14, TW=8. Advance to l=4, b=5 -> RD=5/21, TW=5.
- 80 ADDR_EN pulses spaced 6 cycles -> DONE high exactly one cycle after the 80th, BUSY low, then IDLE; scoreboard checks all 80 read pairs cover each address once per layer.
- ADDR_EN while IDLE -> SEQ_ERR=1 and counters unchanged; subsequent START -> SEQ_ERR=0.
- Mid-run (l=2) EN=0 with ADDR_EN pulses -> no advance. START at l=3 -> LAYER=0, b=0. RST at l=1 -> IDLE, no DONE.

Source files
------------

// File: rtl/fft_iter_addr_gen.sv
// Address generator for a single-butterfly iterative radix-2 DIT FFT.
// Steps butterfly/layer counters on ADDR_EN and derives read, write and twiddle addresses.
module fft_iter_addr_gen #(
    parameter int LAYERS      = 5,
    parameter int BUTTERFLYES = 16,
    parameter int LayWL       = 3,
    parameter int ButtWL      = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              START,
    input  logic              ADDR_EN,
    output logic [ButtWL:0]   RD_ADDR_A,
    output logic [ButtWL:0]   RD_ADDR_B,
    output logic [ButtWL-1:0] TW_ADDR,
    output logic [ButtWL:0]   WR_ADDR_A,
    output logic [ButtWL:0]   WR_ADDR_B,
    output logic [LayWL-1:0]  LAYER,
    output logic              FIRST,
    output logic              BUSY,
    output logic              DONE,
    output logic              SEQ_ERR
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [ButtWL-1:0] B_LAST = ButtWL'(BUTTERFLYES - 1);
    localparam logic [LayWL-1:0]  L_LAST = LayWL'(LAYERS - 1);

    state_t            state, state_nxt;
    logic [ButtWL-1:0] b, b_nxt;
    logic [LayWL-1:0]  l, l_nxt;
    logic [ButtWL:0]   wr_a, wr_a_nxt;
    logic [ButtWL:0]   wr_b, wr_b_nxt;
    logic              seq_err, seq_err_nxt;

    logic [ButtWL:0]   b_ext;
    logic [ButtWL:0]   span;
    logic [ButtWL:0]   m;
    logic [ButtWL:0]   rd_a;
    logic [ButtWL:0]   tw_full;
    logic [LayWL-1:0]  l_plus;
    logic [LayWL-1:0]  tw_shift;

    // Addresses depend only on the counter flops, so they never glitch with inputs.
    always_comb begin
        b_ext    = {1'b0, b};
        span     = {{ButtWL{1'b0}}, 1'b1} << l;
        m        = b_ext & (span - 1'b1);
        l_plus   = l + 1'b1;
        rd_a     = ((b_ext >> l) << l_plus) | m;
        tw_shift = L_LAST - l;
        tw_full  = m << tw_shift;
    end

    assign RD_ADDR_A = rd_a;
    assign RD_ADDR_B = rd_a + span;
    assign TW_ADDR   = tw_full[ButtWL-1:0];
    assign WR_ADDR_A = wr_a;
    assign WR_ADDR_B = wr_b;
    assign LAYER     = l;
    assign FIRST     = (state == RUN) && (l == '0);
    assign BUSY      = (state == RUN);
    assign DONE      = (state == FIN);
    assign SEQ_ERR   = seq_err;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            b       <= '0;
            l       <= '0;
            wr_a    <= '0;
            wr_b    <= '0;
            seq_err <= 1'b0;
        end else if (EN) begin
            state   <= state_nxt;
            b       <= b_nxt;
            l       <= l_nxt;
            wr_a    <= wr_a_nxt;
            wr_b    <= wr_b_nxt;
            seq_err <= seq_err_nxt;
        end
    end

    // START overrides everything; a strobe outside RUN is a protocol error.
    always_comb begin
        state_nxt   = state;
        b_nxt       = b;
        l_nxt       = l;
        wr_a_nxt    = wr_a;
        wr_b_nxt    = wr_b;
        seq_err_nxt = seq_err;
        if (START) begin
            state_nxt   = RUN;
            b_nxt       = '0;
            l_nxt       = '0;
            seq_err_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    b_nxt = '0;
                    l_nxt = '0;
                    if (ADDR_EN) seq_err_nxt = 1'b1;
                end
                RUN: begin
                    if (ADDR_EN) begin
                        wr_a_nxt = RD_ADDR_A;
                        wr_b_nxt = RD_ADDR_B;
                        if (b != B_LAST) begin
                            b_nxt = b + 1'b1;
                        end else begin
                            b_nxt = '0;
                            if (l != L_LAST) begin
                                l_nxt = l + 1'b1;
                            end else begin
                                l_nxt     = '0;
                                state_nxt = FIN;
                            end
                        end
                    end
                end
                FIN: begin
                    state_nxt = IDLE;
                    b_nxt     = '0;
                    l_nxt     = '0;
                    if (ADDR_EN) seq_err_nxt = 1'b1;
                end
                default: begin
                    state_nxt = IDLE;
                    b_nxt     = '0;
                    l_nxt     = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_iter_addr_gen.sv
// Directed bench for fft_iter_addr_gen: hand-computed address points plus a
// full-transform scoreboard that checks each layer touches every address once.
module tb_fft_iter_addr_gen;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN = 1'b1;
    logic       START = 1'b0;
    logic       ADDR_EN = 1'b0;
    logic [4:0] RD_ADDR_A, RD_ADDR_B, WR_ADDR_A, WR_ADDR_B;
    logic [3:0] TW_ADDR;
    logic [2:0] LAYER;
    logic       FIRST, BUSY, DONE, SEQ_ERR;

    int checks = 0;
    int errors = 0;
    logic [31:0] seen [5];

    fft_iter_addr_gen #(
        .LAYERS(5), .BUTTERFLYES(16), .LayWL(3), .ButtWL(4)
    ) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .START(START), .ADDR_EN(ADDR_EN),
        .RD_ADDR_A(RD_ADDR_A), .RD_ADDR_B(RD_ADDR_B), .TW_ADDR(TW_ADDR),
        .WR_ADDR_A(WR_ADDR_A), .WR_ADDR_B(WR_ADDR_B), .LAYER(LAYER),
        .FIRST(FIRST), .BUSY(BUSY), .DONE(DONE), .SEQ_ERR(SEQ_ERR)
    );

    always #5 CLK = ~CLK;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_addr_en(input int n);
        for (int i = 0; i < n; i++) begin
            ADDR_EN = 1'b1;
            tick();
            ADDR_EN = 1'b0;
        end
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int lay, bi, span, exp_a, exp_b, exp_tw;

        // Reset state
        ticks(2);
        RST = 1'b0;
        tick();
        check_output("rst_rd_a", RD_ADDR_A, 0);
        check_output("rst_rd_b", RD_ADDR_B, 1);
        check_output("rst_tw", TW_ADDR, 0);
        check_output("rst_layer", LAYER, 0);
        check_output("rst_busy", BUSY, 0);
        check_output("rst_done", DONE, 0);
        check_output("rst_seq_err", SEQ_ERR, 0);
        check_output("rst_first", FIRST, 0);
        check_output("rst_wr_a", WR_ADDR_A, 0);

        // First butterfly
        pulse_start();
        check_output("start_busy", BUSY, 1);
        check_output("start_first", FIRST, 1);
        pulse_addr_en(1);
        check_output("p1_wr_a", WR_ADDR_A, 0);
        check_output("p1_wr_b", WR_ADDR_B, 1);
        check_output("p1_rd_a", RD_ADDR_A, 2);
        check_output("p1_rd_b", RD_ADDR_B, 3);
        check_output("p1_first", FIRST, 1);

        // Into layer 1
        pulse_addr_en(15);
        check_output("l1_layer", LAYER, 1);
        check_output("l1_first", FIRST, 0);
        pulse_addr_en(1);
        check_output("l1b1_rd_a", RD_ADDR_A, 1);
        check_output("l1b1_rd_b", RD_ADDR_B, 3);
        check_output("l1b1_tw", TW_ADDR, 8);

        // l=2, b=6
        pulse_addr_en(21);
        check_output("l2b6_layer", LAYER, 2);
        check_output("l2b6_rd_a", RD_ADDR_A, 10);
        check_output("l2b6_rd_b", RD_ADDR_B, 14);
        check_output("l2b6_tw", TW_ADDR, 8);

        // Global enable low freezes everything
        EN = 1'b0;
        pulse_addr_en(3);
        EN = 1'b1;
        check_output("en0_rd_a", RD_ADDR_A, 10);
        check_output("en0_layer", LAYER, 2);

        // Restart at l=3; last write was l=2,b=15 -> 27/31
        pulse_addr_en(10);
        check_output("l3_layer", LAYER, 3);
        pulse_start();
        check_output("restart_layer", LAYER, 0);
        check_output("restart_rd_a", RD_ADDR_A, 0);
        check_output("restart_rd_b", RD_ADDR_B, 1);
        check_output("restart_wr_a", WR_ADDR_A, 27);
        check_output("restart_wr_b", WR_ADDR_B, 31);
        check_output("restart_done", DONE, 0);
        check_output("restart_busy", BUSY, 1);

        // l=4, b=5, then finish the transform
        pulse_addr_en(69);
        check_output("l4b5_layer", LAYER, 4);
        check_output("l4b5_rd_a", RD_ADDR_A, 5);
        check_output("l4b5_rd_b", RD_ADDR_B, 21);
        check_output("l4b5_tw", TW_ADDR, 5);
        pulse_addr_en(10);
        check_output("pre_last_done", DONE, 0);
        pulse_addr_en(1);
        check_output("fin_done", DONE, 1);
        check_output("fin_busy", BUSY, 0);
        check_output("fin_wr_a", WR_ADDR_A, 15);
        check_output("fin_wr_b", WR_ADDR_B, 31);
        tick();
        check_output("idle_done", DONE, 0);
        check_output("idle_busy", BUSY, 0);

        // Stray strobe in IDLE
        pulse_addr_en(1);
        check_output("seq_err_set", SEQ_ERR, 1);
        check_output("seq_err_layer", LAYER, 0);
        check_output("seq_err_rd_a", RD_ADDR_A, 0);
        check_output("seq_err_busy", BUSY, 0);
        pulse_start();
        check_output("seq_err_clr", SEQ_ERR, 0);

        // Full transform, strobes every 6 cycles, against an independent model
        for (int k = 0; k < 5; k++) seen[k] = '0;
        for (int k = 0; k < 80; k++) begin
            lay    = k / 16;
            bi     = k % 16;
            span   = 1 << lay;
            exp_a  = (bi / span) * 2 * span + (bi % span);
            exp_b  = exp_a + span;
            exp_tw = (bi % span) * (16 >> lay);
            ticks(5);
            check_output($sformatf("sb%0d_layer", k), LAYER, lay);
            check_output($sformatf("sb%0d_rd_a", k), RD_ADDR_A, exp_a);
            check_output($sformatf("sb%0d_rd_b", k), RD_ADDR_B, exp_b);
            check_output($sformatf("sb%0d_tw", k), TW_ADDR, exp_tw);
            check_output($sformatf("sb%0d_done", k), DONE, 0);
            seen[lay][RD_ADDR_A] = 1'b1;
            seen[lay][RD_ADDR_B] = 1'b1;
            pulse_addr_en(1);
        end
        check_output("sb_done", DONE, 1);
        check_output("sb_busy", BUSY, 0);
        for (int k = 0; k < 5; k++)
            check_output($sformatf("sb_cover_l%0d", k), seen[k], 32'hFFFF_FFFF);
        tick();
        check_output("sb_done_once", DONE, 0);
        check_output("sb_idle_busy", BUSY, 0);

        // Reset in the middle of layer 1
        pulse_start();
        pulse_addr_en(17);
        check_output("mid_layer", LAYER, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_output("mid_rst_busy", BUSY, 0);
        check_output("mid_rst_done", DONE, 0);
        check_output("mid_rst_layer", LAYER, 0);
        check_output("mid_rst_wr_a", WR_ADDR_A, 0);
        tick();
        check_output("mid_rst_done2", DONE, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
